// File: rtl/sdram_to_fifo_wr_controller.sv
// Purpose : moves one 512-word block from the SDRAM read stream into the output FIFO write port.
// Latency : one cycle from sdram_data/sdram_data_valid to fifo_data/wrreq. All outputs are registered.
// Backpres: fifo_rx_rdy requests a block only when the FIFO has room for all of it. There is no
//           per-word stall: a word that arrives while wrfull is set is dropped and flagged.
//
// Ports:
//   clk, rst_n           single rising-edge clock, asynchronous active-low reset
//   wrusedw, wrfull      FIFO write-side fill level and full flag
//   fifo_rx_rdy          room for one block; request to the SDRAM read engine
//   sdram_tx_rdy         SDRAM engine accepts the request; block data follows
//   sdram_data(_valid)   SDRAM read data stream
//   fifo_data, wrreq     FIFO write port
//   block_done           one-cycle pulse after the last word of a block is written
//   blocks_written       completed block count, wraps at 16 bits
//   overflow_err         sticky: a word was dropped or arrived outside a transfer
module sdram_to_fifo_wr_controller #(
    parameter int DATA_WIDTH      = 16,
    parameter int USEDW_WIDTH     = 10,
    parameter int FIFO_DEPTH      = 1024,
    parameter int WORDS_PER_BLOCK = 512
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [USEDW_WIDTH-1:0] wrusedw,
    input  logic                   wrfull,
    output logic                   fifo_rx_rdy,
    input  logic                   sdram_tx_rdy,
    input  logic [DATA_WIDTH-1:0]  sdram_data,
    input  logic                   sdram_data_valid,
    output logic [DATA_WIDTH-1:0]  fifo_data,
    output logic                   wrreq,
    output logic                   block_done,
    output logic [15:0]            blocks_written,
    output logic                   overflow_err
);

    localparam int CNT_W = $clog2(WORDS_PER_BLOCK);
    localparam int CMP_W = USEDW_WIDTH + 1;

    // One extra bit so the limit is representable even when FIFO_DEPTH
    // equals 2**USEDW_WIDTH.
    localparam logic [CMP_W-1:0] SPACE_LIMIT = CMP_W'(FIFO_DEPTH - WORDS_PER_BLOCK);
    localparam logic [CNT_W-1:0] LAST_WORD   = CNT_W'(WORDS_PER_BLOCK - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        XFER = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                  state_q;
    logic                    fifo_rx_rdy_q;
    logic [DATA_WIDTH-1:0]   fifo_data_q;
    logic                    wrreq_q;
    logic                    block_done_q;
    logic [15:0]             blocks_written_q;
    logic                    overflow_err_q;
    logic [CNT_W-1:0]        word_cnt_q;

    logic [CNT_W-1:0]        word_cnt_d;
    logic [15:0]             blocks_written_d;
    logic                    space_ok;
    logic                    last_word;

    assign space_ok         = !wrfull && ({1'b0, wrusedw} <= SPACE_LIMIT);
    assign word_cnt_d       = word_cnt_q + 1'b1;
    assign blocks_written_d = blocks_written_q + 16'd1;
    assign last_word        = (word_cnt_q == LAST_WORD);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q          <= IDLE;
            fifo_rx_rdy_q    <= 1'b0;
            fifo_data_q      <= '0;
            wrreq_q          <= 1'b0;
            block_done_q     <= 1'b0;
            blocks_written_q <= '0;
            overflow_err_q   <= 1'b0;
            word_cnt_q       <= '0;
        end else begin
            // Write strobe and completion pulse are single-cycle by default.
            wrreq_q      <= 1'b0;
            block_done_q <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (space_ok) begin
                        state_q       <= REQ;
                        fifo_rx_rdy_q <= 1'b1;
                    end
                end

                // Space is not re-checked here: nothing else writes the FIFO,
                // so the room seen in IDLE can only grow.
                REQ: begin
                    if (sdram_tx_rdy) begin
                        state_q       <= XFER;
                        fifo_rx_rdy_q <= 1'b0;
                    end
                end

                XFER: begin
                    if (sdram_data_valid) begin
                        if (!wrfull) begin
                            fifo_data_q <= sdram_data;
                            wrreq_q     <= 1'b1;
                        end else begin
                            overflow_err_q <= 1'b1;
                        end
                        // Dropped words still count: the SDRAM engine sends a
                        // fixed-length block regardless of what we keep.
                        if (last_word) begin
                            word_cnt_q <= '0;
                            state_q    <= DONE;
                        end else begin
                            word_cnt_q <= word_cnt_d;
                        end
                    end
                end

                DONE: begin
                    block_done_q     <= 1'b1;
                    blocks_written_q <= blocks_written_d;
                    state_q          <= IDLE;
                end

                default: begin
                    state_q <= IDLE;
                end
            endcase

            // Data outside a transfer (including alongside tx_rdy in REQ)
            // has nowhere to go; flag it.
            if (sdram_data_valid && (state_q != XFER)) begin
                overflow_err_q <= 1'b1;
            end
        end
    end

    assign fifo_rx_rdy    = fifo_rx_rdy_q;
    assign fifo_data      = fifo_data_q;
    assign wrreq          = wrreq_q;
    assign block_done     = block_done_q;
    assign blocks_written = blocks_written_q;
    assign overflow_err   = overflow_err_q;

endmodule

// File: tb/tb_sdram_to_fifo_wr_controller.sv
// Purpose : self-checking bench for sdram_to_fifo_wr_controller.
// Latency : expected FIFO words are queued when driven and popped when wrreq appears.
// Backpres: wrfull is driven by the bench to force drops and to block requests.
module tb_sdram_to_fifo_wr_controller;

    localparam int DW  = 16;
    localparam int UW  = 10;
    localparam int WPB = 512;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [UW-1:0] wrusedw;
    logic          wrfull;
    logic          fifo_rx_rdy;
    logic          sdram_tx_rdy;
    logic [DW-1:0] sdram_data;
    logic          sdram_data_valid;
    logic [DW-1:0] fifo_data;
    logic          wrreq;
    logic          block_done;
    logic [15:0]   blocks_written;
    logic          overflow_err;

    int            checks = 0;
    int            errors = 0;
    logic [DW-1:0] exp_q[$];
    logic [DW-1:0] mon_exp;
    int            wr_pulses = 0;
    int            done_cnt = 0;
    int            exp_blocks = 0;

    always #5 clk = ~clk;

    sdram_to_fifo_wr_controller dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .wrusedw          (wrusedw),
        .wrfull           (wrfull),
        .fifo_rx_rdy      (fifo_rx_rdy),
        .sdram_tx_rdy     (sdram_tx_rdy),
        .sdram_data       (sdram_data),
        .sdram_data_valid (sdram_data_valid),
        .fifo_data        (fifo_data),
        .wrreq            (wrreq),
        .block_done       (block_done),
        .blocks_written   (blocks_written),
        .overflow_err     (overflow_err)
    );

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard: every wrreq must carry the oldest outstanding expected word.
    always @(posedge clk) begin
        #1;
        if (wrreq === 1'b1) begin
            wr_pulses++;
            if (exp_q.size() == 0) begin
                chk_eq("unexpected_wrreq", 32'(wrreq), 32'd0);
            end else begin
                mon_exp = exp_q.pop_front();
                chk_eq("fifo_data", 32'(fifo_data), 32'(mon_exp));
            end
        end
        if (block_done === 1'b1) done_cnt++;
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n            = 1'b0;
        sdram_tx_rdy     = 1'b0;
        sdram_data_valid = 1'b0;
        sdram_data       = '0;
        @(negedge clk);
        chk_eq("rst_fifo_rx_rdy",    32'(fifo_rx_rdy),    32'd0);
        chk_eq("rst_wrreq",          32'(wrreq),          32'd0);
        chk_eq("rst_block_done",     32'(block_done),     32'd0);
        chk_eq("rst_overflow_err",   32'(overflow_err),   32'd0);
        chk_eq("rst_fifo_data",      32'(fifo_data),      32'd0);
        chk_eq("rst_blocks_written", 32'(blocks_written), 32'd0);
        exp_q.delete();
        wr_pulses  = 0;
        done_cnt   = 0;
        exp_blocks = 0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_rdy();
        int n = 0;
        while (fifo_rx_rdy !== 1'b1 && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk_eq("wait_rdy_timeout", 32'(fifo_rx_rdy), 32'd1);
    endtask

    // Called at a negedge with fifo_rx_rdy high. Sends n words starting at
    // value base; words with index in [drop_lo, drop_hi] are sent with wrfull
    // high. A full block also checks the completion tail and the re-request
    // timing (rdy back two edges after the edge taking the last word).
    task automatic send_words(input int n, input int gap, input int base,
                              input int drop_lo, input int drop_hi);
        int dropped = 0;
        int done_before;
        wr_pulses    = 0;
        sdram_tx_rdy = 1'b1;
        @(negedge clk);
        sdram_tx_rdy = 1'b0;
        for (int i = 0; i < n; i++) begin
            if (gap != 0 && i > 0) begin
                sdram_data_valid = 1'b0;
                @(negedge clk);
            end
            sdram_data_valid = 1'b1;
            sdram_data       = 16'(base + i);
            wrfull           = (i >= drop_lo && i <= drop_hi);
            if (!wrfull) exp_q.push_back(sdram_data);
            else dropped++;
            @(negedge clk);
        end
        sdram_data_valid = 1'b0;
        wrfull           = 1'b0;
        if (n == WPB) begin
            done_before = done_cnt;
            chk_eq("tail1_block_done", 32'(block_done),  32'd0);
            chk_eq("tail1_rx_rdy",     32'(fifo_rx_rdy), 32'd0);
            @(negedge clk);
            exp_blocks++;
            chk_eq("tail2_block_done", 32'(block_done),     32'd1);
            chk_eq("tail2_blocks",     32'(blocks_written), 32'(exp_blocks));
            chk_eq("tail2_rx_rdy",     32'(fifo_rx_rdy),    32'd0);
            chk_eq("block_wr_pulses",  32'(wr_pulses),      32'(n - dropped));
            chk_eq("block_queue_left", 32'(exp_q.size()),   32'd0);
            @(negedge clk);
            chk_eq("tail3_block_done", 32'(block_done),     32'd0);
            chk_eq("tail3_rx_rdy",     32'(fifo_rx_rdy),    32'd1);
            chk_eq("done_pulse_count", 32'(done_cnt - done_before), 32'd1);
        end
    endtask

    initial begin
        rst_n            = 1'b0;
        wrusedw          = '0;
        wrfull           = 1'b0;
        sdram_tx_rdy     = 1'b0;
        sdram_data       = '0;
        sdram_data_valid = 1'b0;

        // Contiguous block right after reset.
        do_reset();
        @(negedge clk);
        chk_eq("rdy_after_reset", 32'(fifo_rx_rdy), 32'd1);
        send_words(WPB, 0, 0, -1, -1);
        chk_eq("blk1_overflow", 32'(overflow_err), 32'd0);

        // Back-to-back gapped block, then a block with three dropped words.
        wait_rdy();
        send_words(WPB, 1, 16'h1000, -1, -1);
        chk_eq("blk2_overflow", 32'(overflow_err), 32'd0);
        wait_rdy();
        send_words(WPB, 0, 16'h2000, 100, 102);
        chk_eq("drop_overflow",  32'(overflow_err),   32'd1);
        chk_eq("blk3_count",     32'(blocks_written), 32'd3);
        repeat (3) @(negedge clk);
        chk_eq("overflow_sticky", 32'(overflow_err), 32'd1);

        // Reset part-way through a block, then a clean block.
        wait_rdy();
        send_words(200, 0, 16'h3000, -1, -1);
        chk_eq("partial_wr_pulses", 32'(wr_pulses), 32'd200);
        do_reset();
        wait_rdy();
        send_words(WPB, 0, 16'h4000, -1, -1);
        chk_eq("post_rst_blocks",   32'(blocks_written), 32'd1);
        chk_eq("post_rst_overflow", 32'(overflow_err),   32'd0);

        // Space boundary and data arriving while idle.
        wrusedw = 10'd513;
        do_reset();
        repeat (3) @(negedge clk);
        chk_eq("rdy_usedw_513", 32'(fifo_rx_rdy), 32'd0);
        wr_pulses        = 0;
        sdram_data_valid = 1'b1;
        sdram_data       = 16'hBEEF;
        @(negedge clk);
        sdram_data_valid = 1'b0;
        @(negedge clk);
        chk_eq("idle_valid_overflow", 32'(overflow_err), 32'd1);
        chk_eq("idle_valid_no_wrreq", 32'(wr_pulses),    32'd0);
        wrusedw = 10'd512;
        @(negedge clk);
        chk_eq("rdy_usedw_512", 32'(fifo_rx_rdy), 32'd1);

        wrusedw = '0;
        wrfull  = 1'b1;
        do_reset();
        repeat (3) @(negedge clk);
        chk_eq("rdy_wrfull", 32'(fifo_rx_rdy), 32'd0);
        wrfull = 1'b0;
        @(negedge clk);
        chk_eq("rdy_wrfull_clear", 32'(fifo_rx_rdy), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/sdram_to_fifo_wr_controller.md
Name: sdram_to_fifo_wr_controller

Overview:
Write-side counterpart of the FIFO-to-SDRAM read path. It advertises to the SDRAM read engine when the output FIFO has room for one 1 KB block (512 x 16-bit words). It then accepts the SDRAM read data stream and drives the FIFO write port (data, wrreq) for exactly one block. It sits between the SDRAM controller read-data bus and the downstream dual-clock FIFO write port, in the FIFO write-clock domain.

Parameters:
DATA_WIDTH, 16, width of SDRAM/FIFO data word
USEDW_WIDTH, 10, width of FIFO wrusedw
FIFO_DEPTH, 1024, FIFO capacity in words
WORDS_PER_BLOCK, 512, words per block (1 KB of 16-bit words)

Ports:
clk  in  1  single clock, all logic on rising edge
rst_n  in  1  asynchronous active-low reset
wrusedw  in  USEDW_WIDTH  FIFO write-side used-word count
wrfull  in  1  FIFO full flag
fifo_rx_rdy  out  1  FIFO can take one block; request to SDRAM read engine
sdram_tx_rdy  in  1  SDRAM engine accepts request; block data follows
sdram_data  in  DATA_WIDTH  SDRAM read data
sdram_data_valid  in  1  sdram_data valid this cycle
fifo_data  out  DATA_WIDTH  FIFO write data
wrreq  out  1  FIFO write request
block_done  out  1  one-cycle pulse after the last word of a block is written
blocks_written  out  16  count of completed blocks, wraps 0xFFFF->0
overflow_err  out  1  sticky error flag

Behaviour:
- Reset (rst_n=0, async): state=IDLE; fifo_rx_rdy, wrreq, block_done, overflow_err = 0; fifo_data = 0; blocks_written = 0; word counter = 0. Reset mid-block discards the partial block. No resume after reset.
- All outputs are registered.
- Space rule: space_ok = (wrfull==0) && (wrusedw <= FIFO_DEPTH - WORDS_PER_BLOCK). Compare using USEDW_WIDTH+1 bits. With defaults, wrusedw <= 512 is ok and 513 is not.
- FSM states: IDLE, REQ, XFER, DONE.
- IDLE: if space_ok, go to REQ and set fifo_rx_rdy=1 on the same edge. sdram_tx_rdy is ignored in IDLE.
- REQ: fifo_rx_rdy stays 1. When sdram_tx_rdy is sampled 1, go to XFER and clear fifo_rx_rdy on that edge. Space is not re-checked in REQ, because this block is the FIFO's only writer.
- XFER: on each cycle with sdram_data_valid=1:
  - if wrfull==0: fifo_data<=sdram_data, wrreq<=1 (1-cycle latency).
  - otherwise: drop the word, keep wrreq<=0, set overflow_err<=1.
  - In both cases the word counter increments (9 bits, 0..511).
  - Cycles with valid=0 give wrreq<=0.
  - The word accepted with counter==WORDS_PER_BLOCK-1 ends the block: go to DONE and clear the counter.
- DONE (1 cycle): block_done=1, blocks_written increments, go to IDLE. wrreq for the final word is high during this cycle.
- sdram_data_valid=1 in IDLE, REQ or DONE: data ignored, no wrreq, overflow_err<=1.
- overflow_err clears only on reset.
- Earliest back-to-back timing: IDLE is re-entered after DONE, so the next fifo_rx_rdy rises no earlier than 2 cycles after the last data word.
- Simultaneous sdram_tx_rdy and sdram_data_valid in REQ: tx_rdy is taken and the data word is ignored and flagged. The SDRAM engine must start data no earlier than the cycle after tx_rdy.

Test Plan:
- Reset, then wrusedw=0, wrfull=0 -> fifo_rx_rdy=1 one cycle later. Pulse sdram_tx_rdy, then send 512 contiguous valid words 0x0000..0x01FF -> 512 wrreq pulses, fifo_data follows each input by 1 cycle, block_done pulses once, blocks_written=1, overflow_err=0.
- wrusedw=513 -> fifo_rx_rdy stays 0. Drop wrusedw to 512 -> fifo_rx_rdy=1 next cycle. Set wrfull=1 -> fifo_rx_rdy stays 0.
- Gapped stream during XFER (valid every other cycle, 512 words) -> exactly 512 wrreq pulses, block_done only after word 511.
- Assert wrfull during XFER for 3 valid words -> those 3 produce no wrreq, overflow_err=1 and stays 1. Block still ends after 512 accepted words.
- Pulse rst_n low after word 200 of a block -> all outputs 0, blocks_written=0. The next full block completes normally with 512 writes.
- Valid data while in IDLE -> no wrreq, overflow_err=1. Run 2 back-to-back blocks -> blocks_written=2, second fifo_rx_rdy rises 2 cycles after the first block's last word.
